// File: rtl/ym_dbg_pkg.sv
// Shared definitions for the debug readout deserializer.
// Contents: FSM state enum, counter-width helper, output buffer depth.
`timescale 1ns/1ps
package ym_dbg_pkg;

  typedef enum logic {
    DBG_IDLE  = 1'b0,
    DBG_SHIFT = 1'b1
  } dbg_state_t;

  localparam int DBG_BUF_DEPTH = 2;

  // Counter width able to index n states; never narrower than one bit.
  function automatic int dbg_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ym_dbg_fifo2.sv
// Two-entry valid/ready buffer for deserialized words ({last, data}).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, wdata  - write request and word; honoured when not full or when
//                  the head is popped in the same cycle
//   ready        - consumer accepts head when valid
//   head, valid  - oldest entry and non-empty flag
//   drop         - push refused because the buffer is full and not popping
`timescale 1ns/1ps
module ym_dbg_fifo2 import ym_dbg_pkg::*; #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ready,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic              drop
);

  logic [DATA_W-1:0] mem [DBG_BUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              full;
  logic              pop;
  logic              wr;

  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);
  assign pop   = valid & ready;
  // When full and popping, wr_ptr equals rd_ptr: the new word takes the
  // slot the departing head just vacated.
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/ym_dbg_deser.sv
// Receiving end of the on-chip serial debug readout chain. Captures the bit
// stream emitted after a parallel load, deserializes it into WORD_WIDTH-bit
// words (NUM_WORDS per frame) and presents them through a 2-entry buffer.
// Ports:
//   MCLK        - master clock (rising edge)
//   reset       - asynchronous active-low reset
//   start       - frame start pulse (coincides with the chain's parallel load)
//   bit_en      - bit strobe; sdi sampled only when high
//   sdi         - serial data
//   out_ready   - consumer handshake
//   clr         - clears sticky flags
//   out_data    - head word; out_valid - buffer non-empty
//   out_last    - head word ends its frame
//   busy        - frame capture in progress
//   frame_done  - one-cycle pulse after the final word of a frame is written
//   ovf         - sticky: word dropped on a full buffer
//   restart_err - sticky: start arrived mid-frame
//   par_err     - sticky parity mismatch (only with YM_DBG_DESER_PARITY_EN)
// Build option: define YM_DBG_DESER_PARITY_EN to expect one even-parity
// strobe after every word; the word is then pushed after the parity strobe.
`timescale 1ns/1ps
module ym_dbg_deser import ym_dbg_pkg::*; #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bit_en,
  input  logic                  sdi,
  input  logic                  out_ready,
  input  logic                  clr,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  ovf,
`ifdef YM_DBG_DESER_PARITY_EN
  output logic                  restart_err,
  output logic                  par_err
`else
  output logic                  restart_err
`endif
);

`ifdef YM_DBG_DESER_PARITY_EN
  localparam int STROBES = WORD_WIDTH + 1;
`else
  localparam int STROBES = WORD_WIDTH;
`endif
  localparam int BCW = dbg_cnt_w(STROBES);
  localparam int WCW = dbg_cnt_w(NUM_WORDS);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(STROBES - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NUM_WORDS - 1);

  dbg_state_t            state;
  logic [BCW-1:0]        bit_cnt;
  logic [WCW-1:0]        word_cnt;
  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] shreg_next;
  logic [WORD_WIDTH-1:0] push_word;
  logic                  strobe;
  logic                  word_end;
  logic                  shift_en;
  logic                  push_drop;
  logic [WORD_WIDTH:0]   head;

  // start outranks a coincident strobe, so that bit is never sampled.
  assign strobe   = (state == DBG_SHIFT) && bit_en && !start;
  assign word_end = strobe && (bit_cnt == BIT_LAST);
  assign busy     = (state == DBG_SHIFT);

  generate
    if (WORD_WIDTH == 1) begin : g_w1
      assign shreg_next = sdi;
    end else if (MSB_FIRST) begin : g_msb
      assign shreg_next = {shreg[WORD_WIDTH-2:0], sdi};
    end else begin : g_lsb
      assign shreg_next = {sdi, shreg[WORD_WIDTH-1:1]};
    end
  endgenerate

`ifdef YM_DBG_DESER_PARITY_EN
  // The final strobe of a word carries parity, not data: no shift, and the
  // already-assembled word is pushed.
  logic par_bad;
  assign shift_en  = strobe && !word_end;
  assign push_word = shreg;
  assign par_bad   = word_end && ((^shreg) != sdi);
`else
  // The final data bit is pushed in the same edge it is sampled.
  assign shift_en  = strobe;
  assign push_word = shreg_next;
`endif

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state       <= DBG_IDLE;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      shreg       <= '0;
      frame_done  <= 1'b0;
      ovf         <= 1'b0;
      restart_err <= 1'b0;
`ifdef YM_DBG_DESER_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      frame_done  <= 1'b0;
      // Set terms are OR-ed after the clear so a same-cycle event wins.
      ovf         <= push_drop | (ovf & ~clr);
      restart_err <= (start && (state == DBG_SHIFT)) | (restart_err & ~clr);
`ifdef YM_DBG_DESER_PARITY_EN
      par_err     <= par_bad | (par_err & ~clr);
`endif
      if (start) begin
        state    <= DBG_SHIFT;
        bit_cnt  <= '0;
        word_cnt <= '0;
        shreg    <= '0;
      end else if (strobe) begin
        if (shift_en) shreg <= shreg_next;
        if (word_end) begin
          bit_cnt <= '0;
          if (word_cnt == WORD_LAST) begin
            state      <= DBG_IDLE;
            word_cnt   <= '0;
            frame_done <= 1'b1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  ym_dbg_fifo2 #(.DATA_W(WORD_WIDTH + 1)) u_fifo (
    .clk   (MCLK),
    .rst_n (reset),
    .push  (word_end),
    .wdata ({(word_cnt == WORD_LAST), push_word}),
    .ready (out_ready),
    .head  (head),
    .valid (out_valid),
    .drop  (push_drop)
  );

  assign out_last = head[WORD_WIDTH];
  assign out_data = head[WORD_WIDTH-1:0];

endmodule

// File: tb/tb_ym_dbg_deser.sv
`timescale 1ns/1ps
module tb_ym_dbg_deser;

`ifdef YM_DBG_DESER_PARITY_EN
  localparam int NSTROBE = 9;
`else
  localparam int NSTROBE = 8;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, bit_en = 1'b0, sdi = 1'b0, out_ready = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_data, m_data, f_data;
  logic a_valid, a_last, a_busy, a_done, a_ovf, a_rerr;
  logic m_valid, m_last, m_busy, m_done, m_ovf, m_rerr;
  logic f_valid, f_last, f_busy, f_done, f_ovf, f_rerr;
`ifdef YM_DBG_DESER_PARITY_EN
  logic a_perr, m_perr, f_perr;
`endif

  // a: LSB-first 2 words, m: MSB-first 2 words, f: LSB-first 4 words
  ym_dbg_deser #(.WORD_WIDTH(8), .NUM_WORDS(2), .MSB_FIRST(1'b0)) dut_a (
    .MCLK(clk), .reset(reset), .start(start), .bit_en(bit_en), .sdi(sdi),
    .out_ready(out_ready), .clr(clr), .out_data(a_data), .out_valid(a_valid),
    .out_last(a_last), .busy(a_busy), .frame_done(a_done), .ovf(a_ovf),
    .restart_err(a_rerr)
`ifdef YM_DBG_DESER_PARITY_EN
    , .par_err(a_perr)
`endif
  );
  ym_dbg_deser #(.WORD_WIDTH(8), .NUM_WORDS(2), .MSB_FIRST(1'b1)) dut_m (
    .MCLK(clk), .reset(reset), .start(start), .bit_en(bit_en), .sdi(sdi),
    .out_ready(out_ready), .clr(clr), .out_data(m_data), .out_valid(m_valid),
    .out_last(m_last), .busy(m_busy), .frame_done(m_done), .ovf(m_ovf),
    .restart_err(m_rerr)
`ifdef YM_DBG_DESER_PARITY_EN
    , .par_err(m_perr)
`endif
  );
  ym_dbg_deser #(.WORD_WIDTH(8), .NUM_WORDS(4), .MSB_FIRST(1'b0)) dut_f (
    .MCLK(clk), .reset(reset), .start(start), .bit_en(bit_en), .sdi(sdi),
    .out_ready(out_ready), .clr(clr), .out_data(f_data), .out_valid(f_valid),
    .out_last(f_last), .busy(f_busy), .frame_done(f_done), .ovf(f_ovf),
    .restart_err(f_rerr)
`ifdef YM_DBG_DESER_PARITY_EN
    , .par_err(f_perr)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [8:0] got_a[$], got_m[$], got_f[$];
  logic [8:0] exp_a[$], exp_m[$], exp_f[$];
  int done_a, done_m, done_f;
  bit act[3];
  int idx[3];
  int exp_done[3];

  // Observe accepted words and frame_done pulses mid-low-phase.
  always @(negedge clk) begin
    #1;
    if (a_valid && out_ready) got_a.push_back({a_last, a_data});
    if (m_valid && out_ready) got_m.push_back({m_last, m_data});
    if (f_valid && out_ready) got_f.push_back({f_last, f_data});
    if (a_done) done_a++;
    if (m_done) done_m++;
    if (f_done) done_f++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Reference model: a frame is NUM_WORDS complete words after start;
  // MSB-first receivers see the stream bit-reversed.
  task automatic model_start();
    for (int d = 0; d < 3; d++) begin
      act[d] = 1'b1;
      idx[d] = 0;
    end
  endtask

  task automatic model_word(input logic [7:0] v);
    if (act[0]) begin
      exp_a.push_back({idx[0] == 1, v});
      idx[0]++;
      if (idx[0] == 2) begin act[0] = 1'b0; exp_done[0]++; end
    end
    if (act[1]) begin
      exp_m.push_back({idx[1] == 1, rev8(v)});
      idx[1]++;
      if (idx[1] == 2) begin act[1] = 1'b0; exp_done[1]++; end
    end
    if (act[2]) begin
      exp_f.push_back({idx[2] == 3, v});
      idx[2]++;
      if (idx[2] == 4) begin act[2] = 1'b0; exp_done[2]++; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; bit_en = 1'b0; clr = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    got_a.delete(); got_m.delete(); got_f.delete();
    exp_a.delete(); exp_m.delete(); exp_f.delete();
    done_a = 0; done_m = 0; done_f = 0;
    for (int d = 0; d < 3; d++) begin
      act[d] = 1'b0; idx[d] = 0; exp_done[d] = 0;
    end
  endtask

  task automatic send_bit(input logic b, input int gap, input bit c);
    repeat (gap) @(negedge clk);
    bit_en = 1'b1; sdi = b; clr = c;
    @(negedge clk);
    bit_en = 1'b0; clr = 1'b0;
  endtask

  task automatic pulse_start(input logic with_bit, input logic b);
    start = 1'b1; bit_en = with_bit; sdi = b;
    @(negedge clk);
    start = 1'b0; bit_en = 1'b0;
    model_start();
  endtask

  // Sends a word LSB first; with parity enabled an even-parity strobe follows.
  task automatic send_word(input logic [7:0] v, input int gap_max,
                           input bit force_par, input logic par_bit, input bit clr_last);
    logic [8:0] bits;
    bits = {force_par ? par_bit : ^v, v};
    for (int i = 0; i < NSTROBE; i++)
      send_bit(bits[i], $urandom_range(0, gap_max), clr_last && (i == NSTROBE - 1));
    model_word(v);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_valid, a_last, a_busy, a_done, a_ovf, a_rerr} !== 6'b0 || a_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_a: flags=%b data=%h, required all zero",
        {a_valid, a_last, a_busy, a_done, a_ovf, a_rerr}, a_data);
    end
    n_checks++;
    if ({m_valid, m_last, m_busy, m_done, m_ovf, m_rerr} !== 6'b0 || m_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_m: flags=%b data=%h, required all zero",
        {m_valid, m_last, m_busy, m_done, m_ovf, m_rerr}, m_data);
    end
    n_checks++;
    if ({f_valid, f_last, f_busy, f_done, f_ovf, f_rerr} !== 6'b0 || f_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_f: flags=%b data=%h, required all zero",
        {f_valid, f_last, f_busy, f_done, f_ovf, f_rerr}, f_data);
    end
`ifdef YM_DBG_DESER_PARITY_EN
    n_checks++;
    if ({a_perr, m_perr, f_perr} !== 3'b0) begin
      n_fail++; $display("FAIL reset_par_err: got %b, required 000", {a_perr, m_perr, f_perr});
    end
`endif
    reset = 1'b1;
    // Strobes in IDLE must be ignored.
    for (int i = 0; i < 20; i++) send_bit(1'b1, 0, 1'b0);
    n_checks++;
    if ({a_valid, a_busy, f_valid, f_busy} !== 4'b0) begin
      n_fail++; $display("FAIL idle_ignore: valid/busy=%b, required 0000", {a_valid, a_busy, f_valid, f_busy});
    end
  endtask

  task automatic test_lsb_frame();
    do_reset();
    out_ready = 1'b1;
    pulse_start(1'b0, 1'b0);
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL lsb_frame_done: done=%b busy=%b, required done=1 busy=0", a_done, a_busy);
    end
    n_checks++;
    if ({a_valid, a_last, a_data} !== {1'b1, 1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL lsb_last_word: valid=%b last=%b data=%h, required 1 1 3c", a_valid, a_last, a_data);
    end
    @(negedge clk);
    n_checks++;
    if (a_done !== 1'b0) begin
      n_fail++; $display("FAIL lsb_done_width: done=%b one cycle later, required 0", a_done);
    end
    pulse_start(1'b0, 1'b0);
    repeat (2) send_word(8'($urandom), 3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (got_a.size() != exp_a.size() || got_m.size() != exp_m.size()) begin
      n_fail++; $display("FAIL lsb_count: got %0d/%0d words, required %0d/%0d",
        got_a.size(), got_m.size(), exp_a.size(), exp_m.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL lsb_word%0d: got {last,data}=%h, required %h", i, got_a[i], exp_a[i]);
      end
    end
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++) begin
      n_checks++;
      if (got_m[i] !== exp_m[i]) begin
        n_fail++; $display("FAIL msb_stream_word%0d: got {last,data}=%h, required %h", i, got_m[i], exp_m[i]);
      end
    end
    n_checks++;
    if (done_a != exp_done[0]) begin
      n_fail++; $display("FAIL lsb_done_count: got %0d pulses, required %0d", done_a, exp_done[0]);
    end
  endtask

  task automatic test_msb();
    do_reset();
    out_ready = 1'b1;
    pulse_start(1'b0, 1'b0);
    send_word(8'h01, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'($urandom), 2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (got_m.size() < 1 || got_m[0] !== 9'h080) begin
      n_fail++; $display("FAIL msb_01: got %h (n=%0d), required 080", got_m.size() ? got_m[0] : 9'h1ff, got_m.size());
    end
    n_checks++;
    if (got_m.size() != exp_m.size()) begin
      n_fail++; $display("FAIL msb_count: got %0d words, required %0d", got_m.size(), exp_m.size());
    end
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++) begin
      n_checks++;
      if (got_m[i] !== exp_m[i]) begin
        n_fail++; $display("FAIL msb_word%0d: got {last,data}=%h, required %h", i, got_m[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_ovf();
    logic [7:0] w[4];
    for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
    do_reset();
    out_ready = 1'b0;
    pulse_start(1'b0, 1'b0);
    send_word(w[0], 1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({f_valid, f_data, f_ovf} !== {1'b1, w[0], 1'b0}) begin
      n_fail++; $display("FAIL ovf_first: valid=%b data=%h ovf=%b, required 1 %h 0", f_valid, f_data, f_ovf, w[0]);
    end
    send_word(w[1], 1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (f_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_second: ovf=%b, required 0", f_ovf);
    end
    send_word(w[2], 1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (f_ovf !== 1'b1 || f_data !== w[0]) begin
      n_fail++; $display("FAIL ovf_third: ovf=%b data=%h, required 1 %h", f_ovf, f_data, w[0]);
    end
    send_word(w[3], 1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({f_ovf, f_done, f_busy} !== 3'b110) begin
      n_fail++; $display("FAIL ovf_set_wins: ovf/done/busy=%b, required 110", {f_ovf, f_done, f_busy});
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (f_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr: ovf=%b, required 0", f_ovf);
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_f.size() != 2 || f_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drain_count: got %0d words valid=%b, required 2 words valid=0", got_f.size(), f_valid);
    end
    for (int i = 0; i < 2 && i < got_f.size(); i++) begin
      n_checks++;
      if (got_f[i] !== {1'b0, w[i]}) begin
        n_fail++; $display("FAIL ovf_drain%0d: got %h, required %h", i, got_f[i], {1'b0, w[i]});
      end
    end
  endtask

  task automatic test_restart();
    do_reset();
    out_ready = 1'b1;
    pulse_start(1'b0, 1'b0);
    n_checks++;
    if (a_rerr !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++; $display("FAIL idle_start: restart_err=%b busy=%b, required 0 1", a_rerr, a_busy);
    end
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 0, 1'b0);
    pulse_start(1'b1, 1'($urandom_range(0, 1)));
    n_checks++;
    if ({a_rerr, a_busy, a_valid} !== 3'b110) begin
      n_fail++; $display("FAIL restart_flag: rerr/busy/valid=%b, required 110", {a_rerr, a_busy, a_valid});
    end
    send_word(8'h12, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'($urandom), 1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (got_a.size() < 1 || got_a[0] !== 9'h012) begin
      n_fail++; $display("FAIL restart_first: got %h (n=%0d), required 012", got_a.size() ? got_a[0] : 9'h1ff, got_a.size());
    end
    n_checks++;
    if (got_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL restart_count: got %0d words, required %0d", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL restart_word%0d: got %h, required %h", i, got_a[i], exp_a[i]);
      end
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (a_rerr !== 1'b0) begin
      n_fail++; $display("FAIL restart_clr: restart_err=%b, required 0", a_rerr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    pulse_start(1'b0, 1'b0);
    send_word(8'($urandom), 0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (a_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: valid=%b, required 1", a_valid);
    end
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({a_valid, a_busy, a_data} !== 10'b0) begin
      n_fail++; $display("FAIL areset_now: valid=%b busy=%b data=%h, required 0 0 00", a_valid, a_busy, a_data);
    end
    do_reset();
    out_ready = 1'b1;
    pulse_start(1'b0, 1'b0);
    repeat (2) send_word(8'($urandom), 2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (got_a.size() != exp_a.size() || done_a != 1) begin
      n_fail++; $display("FAIL areset_after: got %0d words %0d done, required %0d words 1 done",
        got_a.size(), done_a, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL areset_word%0d: got %h, required %h", i, got_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int fr = 0; fr < 4; fr++) begin
      pulse_start(1'b0, 1'b0);
      for (int w = 0; w < 4; w++) send_word(8'($urandom), 2, 1'b0, 1'b0, 1'b0);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (a_rerr !== 1'b0 || f_rerr !== 1'b0) begin
      n_fail++; $display("FAIL b2b_no_restart: rerr a=%b f=%b, required 0 0", a_rerr, f_rerr);
    end
    n_checks++;
    if (done_a != exp_done[0] || done_m != exp_done[1] || done_f != exp_done[2]) begin
      n_fail++; $display("FAIL b2b_done: got %0d/%0d/%0d, required %0d/%0d/%0d",
        done_a, done_m, done_f, exp_done[0], exp_done[1], exp_done[2]);
    end
    n_checks++;
    if (got_a.size() != exp_a.size() || got_m.size() != exp_m.size() || got_f.size() != exp_f.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d/%0d/%0d, required %0d/%0d/%0d",
        got_a.size(), got_m.size(), got_f.size(), exp_a.size(), exp_m.size(), exp_f.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL b2b_a%0d: got %h, required %h", i, got_a[i], exp_a[i]);
      end
    end
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++) begin
      n_checks++;
      if (got_m[i] !== exp_m[i]) begin
        n_fail++; $display("FAIL b2b_m%0d: got %h, required %h", i, got_m[i], exp_m[i]);
      end
    end
    for (int i = 0; i < exp_f.size() && i < got_f.size(); i++) begin
      n_checks++;
      if (got_f[i] !== exp_f[i]) begin
        n_fail++; $display("FAIL b2b_f%0d: got %h, required %h", i, got_f[i], exp_f[i]);
      end
    end
  endtask

`ifdef YM_DBG_DESER_PARITY_EN
  task automatic test_parity();
    logic [7:0] v;
    do_reset();
    out_ready = 1'b1;
    pulse_start(1'b0, 1'b0);
    v = 8'h07;
    for (int i = 0; i < 8; i++) send_bit(v[i], 0, 1'b0);
    n_checks++;
    if (a_valid !== 1'b0) begin
      n_fail++; $display("FAIL par_no_early_push: valid=%b before parity strobe, required 0", a_valid);
    end
    send_bit(1'b0, 0, 1'b0);
    model_word(v);
    n_checks++;
    if ({a_perr, a_valid, a_data} !== {1'b1, 1'b1, 8'h07}) begin
      n_fail++; $display("FAIL par_bad: par_err=%b valid=%b data=%h, required 1 1 07", a_perr, a_valid, a_data);
    end
    send_word(8'($urandom), 1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (a_perr !== 1'b1) begin
      n_fail++; $display("FAIL par_sticky: par_err=%b, required 1", a_perr);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (a_perr !== 1'b0) begin
      n_fail++; $display("FAIL par_clr: par_err=%b, required 0", a_perr);
    end
    pulse_start(1'b0, 1'b0);
    send_word(8'h07, 0, 1'b1, 1'b1, 1'b0);
    send_word(8'($urandom), 2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_perr !== 1'b0) begin
      n_fail++; $display("FAIL par_good: par_err=%b, required 0", a_perr);
    end
    n_checks++;
    if (got_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL par_count: got %0d words, required %0d", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL par_word%0d: got %h, required %h", i, got_a[i], exp_a[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_frame();
    test_msb();
    test_ovf();
    test_restart();
    test_async_reset();
    test_back_to_back();
`ifdef YM_DBG_DESER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ym_dbg_deser.md
Name: ym_dbg_deser

Overview:
- Receiving end of the on-chip serial debug readout chain.
- Captures the serial bit stream that a debug-read shift chain emits after a parallel load. Deserializes it into WORD_WIDTH-bit words and presents them through a 2-entry valid/ready output buffer.
- Sits between a chip core's debug chain output and a host-side register or logging interface.

Parameters:
- WORD_WIDTH, 8, bits per deserialized word (1..32).
- NUM_WORDS, 4, words per frame (1..256).
- MSB_FIRST, 0. 0: first received bit lands in bit 0 (LSB-first chain). 1: first received bit lands in bit WORD_WIDTH-1 (MSB-first chain).

Ports:
- MCLK, input, 1, master clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse coincident with the chain's parallel load; begins a frame.
- bit_en, input, 1, bit strobe; sdi is sampled only on cycles where bit_en=1.
- sdi, input, 1, serial data from the chain output.
- out_ready, input, 1, consumer accepts out_data when out_valid=1.
- clr, input, 1, synchronous clear of sticky flags ovf and restart_err.
- out_data, output, WORD_WIDTH, head word of the output buffer.
- out_valid, output, 1, output buffer non-empty.
- out_last, output, 1, head word is the final word of its frame.
- busy, output, 1, frame capture in progress.
- frame_done, output, 1, one-cycle pulse after the final word of a frame is written.
- ovf, output, 1, sticky: a completed word was dropped because the buffer was full.
- restart_err, output, 1, sticky: start arrived while busy.

Behaviour:
- Reset (asynchronous, reset=0):
  - All outputs 0, buffer empty, FSM in IDLE.
  - Bit and word counters are 0; the shift register is 0.
- FSM states: IDLE and SHIFT.
- IDLE:
  - start=1 -> SHIFT; bit_cnt=0, word_cnt=0.
  - bit_en is ignored in IDLE.
- SHIFT:
  - busy=1.
  - Each bit_en cycle shifts sdi into the shift register. MSB_FIRST=0 shifts right with insertion at the top, so the first bit ends up in bit 0. MSB_FIRST=1 shifts left with insertion at bit 0.
  - bit_cnt increments on each bit_en.
  - On the bit_en cycle where bit_cnt=WORD_WIDTH-1, the completed word is pushed into the buffer at the next MCLK edge. bit_cnt wraps to 0 and word_cnt increments.
  - out_last is stored with the word: it is 1 when word_cnt=NUM_WORDS-1.
  - After the push of word NUM_WORDS-1: return to IDLE, and frame_done pulses high for exactly one cycle.
- Latency: a word appears on out_data/out_valid one MCLK cycle after its final bit_en cycle, provided the buffer was not full.
- start and bit_en in the same cycle: start takes priority and that bit is not sampled. The chain emits its first valid bit on a later strobe.
- start while in SHIFT:
  - The partial word is discarded and counters reset to 0; the FSM stays in SHIFT.
  - restart_err is set.
  - Words already buffered are kept.
- Output buffer:
  - 2-entry FIFO. Pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when the buffer is full: the pop frees a slot for the push.
  - Push while full with no pop: the word is dropped and ovf is set. Frame counting continues, so the frame still ends after NUM_WORDS words.
- Sticky flags:
  - clr=1 clears ovf and restart_err.
  - A set condition in the same cycle as clr wins: the flag stays set.
- Counter widths: bit_cnt is clog2(WORD_WIDTH) bits, minimum 1; word_cnt is clog2(NUM_WORDS) bits, minimum 1.
- out_data holds its value while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: YM_DBG_DESER_PARITY_EN.
- When defined:
  - Each word is followed by one extra bit_en strobe carrying even parity over the word's WORD_WIDTH bits.
  - The word is pushed one cycle after the parity strobe, not after its last data bit.
  - Adds output port par_err (1 bit, sticky, reset 0, cleared by clr) that is set on mismatch. The word is still pushed.
- When undefined: no parity bit, no par_err port, and timing is as described above.

Decomposition:
- Shared package ym_dbg_pkg holds:
  - the FSM state enum (DBG_IDLE, DBG_SHIFT);
  - the clog2-based counter-width constant functions;
  - the buffer depth constant DBG_BUF_DEPTH=2.
- One natural sub-module: ym_dbg_fifo2 (2-entry valid/ready buffer carrying {last, data}, with a full flag and a push-drop indication).

Test Plan:
- LSB-first, WORD_WIDTH=8, NUM_WORDS=2; start, then 16 strobes carrying 0xA5 and 0x3C LSB-first with out_ready=1 -> out_data 0xA5 (out_last=0), then 0x3C (out_last=1); frame_done pulses once, one cycle after the 16th strobe.
- MSB_FIRST=1, same bit stream -> words 0xA5 bit-reversed = 0xA5 and 0x3C bit-reversed = 0x3C; repeat with 0x01 -> received 0x80.
- out_ready=0, NUM_WORDS=4 -> first two words buffered, third and fourth dropped, ovf=1 after the third word; then clr -> ovf=0; out_ready=1 drains exactly two words.
- start after 5 bits of a word -> restart_err=1; next 8 strobes carrying 0x12 -> first pushed word is 0x12 and no partial word appears.
- Assert reset mid-frame after 3 bits -> out_valid=0 and busy=0 immediately (asynchronous); after release, a new frame captures correctly.
- With YM_DBG_DESER_PARITY_EN: word 0x07 followed by parity bit 0 (odd count, so wrong) -> par_err=1, word 0x07 still delivered; correct parity bit 1 -> par_err stays 0.
